// File: rtl/draw_list_scheduler_pkg.sv
// Shared types and sizes for the per-scanline draw-list scheduler.
// Latency: n/a (types only). Backpressure: n/a.
package draw_pkg;
  localparam int N_OBJ  = 16;
  localparam int N_SLOT = 4;
  localparam int XW     = 10;
  localparam int HW     = 6;
  localparam int IW     = $clog2(N_OBJ);
  localparam int SW     = $clog2(N_SLOT);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [HW-1:0] h;
    logic          en;
  } obj_t;
endpackage

// File: rtl/draw_list_scheduler_if.sv
// Object-table write bus from game logic plus the active draw list toward the color mapper.
// Latency: n/a (wiring only). Backpressure: none, writes and list are always accepted/valid.
interface draw_list_scheduler_if import draw_pkg::*; ();
  logic                 obj_wr;
  logic [IW-1:0]        obj_idx;
  logic [XW-1:0]        obj_x;
  logic [XW-1:0]        obj_y;
  logic [HW-1:0]        obj_h;
  logic                 obj_en;
  logic [N_SLOT-1:0]    slot_valid;
  logic [XW*N_SLOT-1:0] slot_x;
  logic [IW*N_SLOT-1:0] slot_id;

  modport master (output obj_wr, obj_idx, obj_x, obj_y, obj_h, obj_en,
                  input  slot_valid, slot_x, slot_id);
  modport slave  (input  obj_wr, obj_idx, obj_x, obj_y, obj_h, obj_en,
                  output slot_valid, slot_x, slot_id);
endinterface

// File: rtl/draw_list_scheduler_obj_table.sv
// Staging object table written by game logic, live copy committed in one cycle, live read at rd_idx.
// Latency: write/commit 1 cycle, read combinational. Backpressure: none.
module draw_list_scheduler_obj_table import draw_pkg::*; (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic [IW-1:0] wr_idx,
  input  obj_t          wr_obj,
  input  logic          commit,
  input  logic [IW-1:0] rd_idx,
  output obj_t          rd_obj
);
  obj_t staging [N_OBJ];
  obj_t live    [N_OBJ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_OBJ; i++) begin
        staging[i] <= '0;
        live[i]    <= '0;
      end
    end else begin
      if (wr)
        staging[wr_idx] <= wr_obj;
      // A write landing in the commit cycle is forwarded into the live copy.
      if (commit)
        for (int i = 0; i < N_OBJ; i++)
          live[i] <= (wr && wr_idx == IW'(i)) ? wr_obj : staging[i];
    end
  end

  assign rd_obj = live[rd_idx];
endmodule

// File: rtl/draw_list_scheduler.sv
// Scans the live object table once per line and publishes up to N_SLOT hits at the next line_start.
// Latency: scan N_OBJ cycles; list visible 1 cycle after line_start. Backpressure: none, late scans flagged.
module draw_list_scheduler import draw_pkg::*; (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_start,
  input  logic                 line_start,
  input  logic [XW-1:0]        next_y,
  draw_list_scheduler_if.slave bus,
  output logic                 scan_busy,
  output logic                 line_ovf,
  output logic                 scan_late
);
  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [XW-1:0]        y_lat;
  logic [N_SLOT-1:0]    pend_vld;
  logic [XW-1:0]        pend_x  [N_SLOT];
  logic [IW-1:0]        pend_id [N_SLOT];
  logic [N_SLOT-1:0]    act_valid;
  logic [XW*N_SLOT-1:0] act_x;
  logic [IW*N_SLOT-1:0] act_id;

  obj_t                 cur;
  obj_t                 wr_obj;
  logic [XW:0]          y11, top11, bot11;
  logic                 hit, free_any, ovf_set, late_set;
  logic [SW-1:0]        free_idx;

  assign wr_obj = {bus.obj_x, bus.obj_y, bus.obj_h, bus.obj_en};

  draw_list_scheduler_obj_table u_table (
    .clk    (Clk),
    .reset  (Reset),
    .wr     (bus.obj_wr),
    .wr_idx (bus.obj_idx),
    .wr_obj (wr_obj),
    .commit (frame_start),
    .rd_idx (idx),
    .rd_obj (cur)
  );

  // 11-bit compare so y+h past the last line cannot wrap back to the top.
  assign y11   = {1'b0, y_lat};
  assign top11 = {1'b0, cur.y};
  assign bot11 = top11 + (XW+1)'(cur.h);
  assign hit   = (state == SCAN) && cur.en && (cur.h != '0) && (y11 >= top11) && (y11 < bot11);

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int k = N_SLOT-1; k >= 0; k--)
      if (!pend_vld[k]) begin
        free_any = 1'b1;
        free_idx = SW'(k);
      end
  end

  assign ovf_set  = hit && !free_any && !line_start;
  assign late_set = line_start && (state == SCAN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      idx       <= '0;
      y_lat     <= '0;
      pend_vld  <= '0;
      act_valid <= '0;
      act_x     <= '0;
      act_id    <= '0;
      scan_busy <= 1'b0;
      line_ovf  <= 1'b0;
      scan_late <= 1'b0;
      for (int k = 0; k < N_SLOT; k++) begin
        pend_x[k]  <= '0;
        pend_id[k] <= '0;
      end
    end else begin
      line_ovf  <= ovf_set  | (line_ovf  & ~frame_start);
      scan_late <= late_set | (scan_late & ~frame_start);
      if (line_start) begin
        act_valid <= pend_vld;
        for (int k = 0; k < N_SLOT; k++) begin
          act_x[k*XW +: XW] <= pend_x[k];
          act_id[k*IW +: IW] <= pend_id[k];
        end
        pend_vld  <= '0;
        y_lat     <= next_y;
        idx       <= '0;
        state     <= SCAN;
        scan_busy <= 1'b1;
      end else if (state == SCAN) begin
        if (hit && free_any) begin
          pend_vld[free_idx] <= 1'b1;
          pend_x[free_idx]   <= cur.x;
          pend_id[free_idx]  <= idx;
        end
        if (idx == IW'(N_OBJ-1)) begin
          state     <= IDLE;
          scan_busy <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign bus.slot_valid = act_valid;
  assign bus.slot_x     = act_x;
  assign bus.slot_id    = act_id;
endmodule
